// File: rtl/pcm_frame_buffer.sv
// Ping-pong PCM frame buffer: packs the sample stream into two RAM banks and serves full frames by address.
// Optional PCM_DROP_CNT_EN adds a saturating 16-bit drop_count output.
module pcm_frame_buffer #(
  parameter int BIT_DEPTH = 8,
  parameter int FRAME_LEN = 64,
  localparam int ADDR_W = $clog2(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_DEPTH-1:0] data,
  input  logic                 data_valid,
  output logic                 frame_valid,
  output logic                 rd_bank,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [BIT_DEPTH-1:0] rd_data,
  output logic                 rd_data_valid,
  input  logic                 frame_done,
  output logic                 wr_bank,
  output logic [ADDR_W-1:0]    wr_addr,
`ifdef PCM_DROP_CNT_EN
  output logic                 overflow,
  output logic [15:0]          drop_count
`else
  output logic                 overflow
`endif
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    LAST  = 2'd1,
    STALL = 2'd2
  } wr_state_t;

  wr_state_t state_q, state_d;

  logic [1:0] full_q, full_d;
  logic       release_rd;
  logic       wr_en;
  logic       frame_complete;
  logic       drop;
  logic       rd_fire;

  logic [BIT_DEPTH-1:0] mem [2*FRAME_LEN];

  assign frame_valid    = full_q[rd_bank];
  assign release_rd     = frame_done && frame_valid;
  assign wr_en          = data_valid && (state_q != STALL);
  assign frame_complete = wr_en && (state_q == LAST);
  assign drop           = data_valid && (state_q == STALL);
  assign rd_fire        = rd_en && frame_valid;

  // Completion and release never target the same bank, so both edits apply independently.
  always_comb begin
    full_d = full_q;
    if (frame_complete) full_d[wr_bank] = 1'b1;
    if (release_rd)     full_d[rd_bank] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (data_valid && (wr_addr == ADDR_W'(FRAME_LEN - 2)))
          state_d = LAST;
      end
      LAST: begin
        if (data_valid)
          state_d = full_d[!wr_bank] ? STALL : FILL;
      end
      STALL: begin
        // A sample in the release cycle is still dropped; writing resumes on the next one.
        if (!full_d[wr_bank])
          state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      full_q   <= 2'b00;
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      rd_bank  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      if (wr_en) begin
        if (state_q == LAST) begin
          wr_addr <= '0;
          wr_bank <= !wr_bank;
        end else begin
          wr_addr <= wr_addr + ADDR_W'(1);
        end
      end
      if (drop)
        overflow <= 1'b1;
      if (release_rd)
        rd_bank <= !rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst)
      mem[{wr_bank, wr_addr}] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_fire;
      if (rd_fire)
        rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

`ifdef PCM_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      drop_count <= 16'd0;
    else if (drop && (drop_count != 16'hFFFF))
      drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pcm_frame_buffer.sv
// Self-checking bench for pcm_frame_buffer: a queue-level reference model compared every cycle,
// plus hand-computed literal checks for each directed scenario.
module tb_pcm_frame_buffer;

  localparam int BD = 8;
  localparam int FL = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [BD-1:0] data;
  logic          data_valid;
  logic          frame_valid;
  logic          rd_bank;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [BD-1:0] rd_data;
  logic          rd_data_valid;
  logic          frame_done;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          overflow;
`ifdef PCM_DROP_CNT_EN
  logic [15:0]   drop_count;
`endif

  always #5 clk = ~clk;

  pcm_frame_buffer #(.BIT_DEPTH(BD), .FRAME_LEN(FL)) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .data_valid(data_valid),
    .frame_valid(frame_valid),
    .rd_bank(rd_bank),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_data_valid(rd_data_valid),
    .frame_done(frame_done),
    .wr_bank(wr_bank),
    .wr_addr(wr_addr),
`ifdef PCM_DROP_CNT_EN
    .overflow(overflow),
    .drop_count(drop_count)
`else
    .overflow(overflow)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: two frame buffers with full flags; a bank accepts samples only while not full.
  bit            m_ok = 1'b0;
  bit [1:0]      m_full;
  bit            m_wr_bank, m_rd_bank, m_over, m_rdv;
  int            m_wr_addr;
  int            m_drops;
  logic [BD-1:0] m_rd_data;
  logic [BD-1:0] m_mem [2][FL];
  bit [1:0]      o_full;
  bit            o_rd, o_wb;

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1; m_full = 2'b00; m_wr_bank = 1'b0; m_rd_bank = 1'b0;
      m_over = 1'b0; m_rdv = 1'b0; m_wr_addr = 0; m_drops = 0; m_rd_data = '0;
    end else if (m_ok) begin
      o_full = m_full; o_rd = m_rd_bank; o_wb = m_wr_bank;
      m_rdv = rd_en && o_full[o_rd];
      if (m_rdv) m_rd_data = m_mem[o_rd][rd_addr];
      if (data_valid) begin
        if (!o_full[o_wb]) begin
          m_mem[o_wb][m_wr_addr] = data;
          m_wr_addr++;
          if (m_wr_addr == FL) begin
            m_wr_addr = 0;
            m_full[o_wb] = 1'b1;
            m_wr_bank = !o_wb;
          end
        end else begin
          m_over = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
      if (frame_done && o_full[o_rd]) begin
        m_full[o_rd] = 1'b0;
        m_rd_bank = !o_rd;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      checkOutput("cmp_frame_valid", 32'(frame_valid), 32'(m_full[m_rd_bank]));
      checkOutput("cmp_rd_bank", 32'(rd_bank), 32'(m_rd_bank));
      checkOutput("cmp_wr_bank", 32'(wr_bank), 32'(m_wr_bank));
      checkOutput("cmp_wr_addr", 32'(wr_addr), 32'(m_wr_addr));
      checkOutput("cmp_overflow", 32'(overflow), 32'(m_over));
      checkOutput("cmp_rd_data_valid", 32'(rd_data_valid), 32'(m_rdv));
      checkOutput("cmp_rd_data", 32'(rd_data), 32'(m_rd_data));
`ifdef PCM_DROP_CNT_EN
      checkOutput("cmp_drop_count", 32'(drop_count), 32'(m_drops));
`endif
    end
  end

  task automatic applyStimulus(input bit dv, input logic [BD-1:0] d, input bit re,
                               input logic [AW-1:0] ra, input bit fd);
    data_valid = dv; data = d; rd_en = re; rd_addr = ra; frame_done = fd;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic writeSample(input logic [BD-1:0] d);
    applyStimulus(1'b1, d, 1'b0, '0, 1'b0);
  endtask

  task automatic readAt(input logic [AW-1:0] a);
    applyStimulus(1'b0, '0, 1'b1, a, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  logic [BD-1:0] t1_exp [4] = '{8'h01, 8'hFE, 8'h03, 8'hFC};

  initial begin
    rst = 1'b1; data_valid = 1'b0; data = '0; rd_en = 1'b0; rd_addr = '0; frame_done = 1'b0;
    @(negedge clk);
    doReset();
    checkOutput("rst_frame_valid", 32'(frame_valid), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_rd_data_valid", 32'(rd_data_valid), 32'd0);

    // 1. Fill one frame with signed samples and read it back.
    writeSample(8'h01); writeSample(8'hFE); writeSample(8'h03); writeSample(8'hFC);
    checkOutput("t1_frame_valid", 32'(frame_valid), 32'd1);
    checkOutput("t1_rd_bank", 32'(rd_bank), 32'd0);
    checkOutput("t1_wr_bank", 32'(wr_bank), 32'd1);
    for (int i = 0; i < 4; i++) begin
      readAt(2'(i));
      checkOutput("t1_rd_data_valid", 32'(rd_data_valid), 32'd1);
      checkOutput("t1_rd_data", 32'(rd_data), 32'(t1_exp[i]));
    end
    idle();
    checkOutput("t1_rd_data_hold", 32'(rd_data), 32'hFC);

    // 2. Ping-pong: read bank 0 while bank 1 fills, then release bank 0.
    doReset();
    for (int i = 0; i < 4; i++) writeSample(8'(10 + i));
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(14 + i), 1'b1, 2'(i), 1'b0);
    checkOutput("t2_bank0_last", 32'(rd_data), 32'd13);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    checkOutput("t2_rd_bank", 32'(rd_bank), 32'd1);
    checkOutput("t2_frame_valid", 32'(frame_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      readAt(2'(i));
      checkOutput("t2_bank1_data", 32'(rd_data), 32'(14 + i));
    end
    checkOutput("t2_overflow", 32'(overflow), 32'd0);

    // 3. Overflow: ten samples with no release drops the last two.
    doReset();
    for (int i = 1; i <= 10; i++) writeSample(8'(i));
    checkOutput("t3_overflow", 32'(overflow), 32'd1);
    checkOutput("t3_wr_addr", 32'(wr_addr), 32'd0);
`ifdef PCM_DROP_CNT_EN
    checkOutput("t3_drop_count", 32'(drop_count), 32'd2);
`endif
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    writeSample(8'd7);
    checkOutput("t3_wr_bank_after", 32'(wr_bank), 32'd0);
    checkOutput("t3_wr_addr_after", 32'(wr_addr), 32'd1);
    writeSample(8'd8); writeSample(8'd9); writeSample(8'd10);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    readAt(2'd0);
    checkOutput("t3_bank0_addr0", 32'(rd_data), 32'd7);
    checkOutput("t3_overflow_sticky", 32'(overflow), 32'd1);

    // 4. A sample on the release cycle is dropped; the next one lands at bank 0 address 0.
    doReset();
    for (int i = 1; i <= 8; i++) writeSample(8'(i));
    applyStimulus(1'b1, 8'h55, 1'b0, '0, 1'b1);
    checkOutput("t4_wr_addr_drop", 32'(wr_addr), 32'd0);
    checkOutput("t4_overflow", 32'(overflow), 32'd1);
    writeSample(8'h66);
    checkOutput("t4_wr_addr_next", 32'(wr_addr), 32'd1);
    checkOutput("t4_wr_bank_next", 32'(wr_bank), 32'd0);
`ifdef PCM_DROP_CNT_EN
    checkOutput("t4_drop_count", 32'(drop_count), 32'd1);
`endif
    writeSample(8'h67); writeSample(8'h68); writeSample(8'h69);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    checkOutput("t4_rd_bank", 32'(rd_bank), 32'd0);
    readAt(2'd0);
    checkOutput("t4_bank0_addr0", 32'(rd_data), 32'h66);
    readAt(2'd3);
    checkOutput("t4_bank0_addr3", 32'(rd_data), 32'h69);

    // 5. Stray frame_done and read with no frame are ignored.
    doReset();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    checkOutput("t5_rd_bank", 32'(rd_bank), 32'd0);
    checkOutput("t5_frame_valid", 32'(frame_valid), 32'd0);
    readAt(2'd1);
    checkOutput("t5_rd_data_valid", 32'(rd_data_valid), 32'd0);
    for (int i = 0; i < 4; i++) writeSample(8'(20 + i));
    checkOutput("t5_frame_valid_after", 32'(frame_valid), 32'd1);
    checkOutput("t5_rd_bank_after", 32'(rd_bank), 32'd0);

    // 6. Mid-frame reset discards the partial frame.
    doReset();
    writeSample(8'h11); writeSample(8'h12);
    doReset();
    checkOutput("t6_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("t6_wr_bank", 32'(wr_bank), 32'd0);
    checkOutput("t6_rd_data", 32'(rd_data), 32'd0);
    checkOutput("t6_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) writeSample(8'(5 + i));
    for (int i = 0; i < 4; i++) begin
      readAt(2'(i));
      checkOutput("t6_rd_data_back", 32'(rd_data), 32'(5 + i));
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
